axi_sram_device: RTL and testbench

AXI_SRAM_DEVICE -- requirements
Module: axi_sram_device

---
 rtl/axi_sram_device_if.sv | 76 +++++++
 rtl/axi_sram_device.sv | 194 +++++++++++++++++++
 tb/tb_axi_sram_device.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/axi_sram_device_if.sv
// rtl/axi_sram_device_if.sv - host-side AXI bus bundle for axi_sram_device
//
// Parameters: IdWidth, AddrWidth, DataWidth (must match the device instance).
// Channels:
//   AW  host_aw_valid/ready, host_aw_id/addr/len/size/burst
//   W   host_w_valid/ready,  host_w_data/strb/last
//   B   host_b_valid/ready,  host_b_id/resp
//   AR  host_ar_valid/ready, host_ar_id/addr/len/size/burst
//   R   host_r_valid/ready,  host_r_id/data/resp/last
// Modports: master (bus initiator), slave (the SRAM device).

interface axi_sram_device_if #(
   parameter int IdWidth   = 1,
   parameter int AddrWidth = 56,
   parameter int DataWidth = 64
);
   logic                   host_aw_valid;
   logic                   host_aw_ready;
   logic [IdWidth-1:0]     host_aw_id;
   logic [AddrWidth-1:0]   host_aw_addr;
   logic [7:0]             host_aw_len;
   logic [2:0]             host_aw_size;
   logic [1:0]             host_aw_burst;

   logic                   host_w_valid;
   logic                   host_w_ready;
   logic [DataWidth-1:0]   host_w_data;
   logic [DataWidth/8-1:0] host_w_strb;
   logic                   host_w_last;

   logic                   host_b_valid;
   logic                   host_b_ready;
   logic [IdWidth-1:0]     host_b_id;
   logic [1:0]             host_b_resp;

   logic                   host_ar_valid;
   logic                   host_ar_ready;
   logic [IdWidth-1:0]     host_ar_id;
   logic [AddrWidth-1:0]   host_ar_addr;
   logic [7:0]             host_ar_len;
   logic [2:0]             host_ar_size;
   logic [1:0]             host_ar_burst;

   logic                   host_r_valid;
   logic                   host_r_ready;
   logic [IdWidth-1:0]     host_r_id;
   logic [DataWidth-1:0]   host_r_data;
   logic [1:0]             host_r_resp;
   logic                   host_r_last;

   modport master (
      output host_aw_valid, host_aw_id, host_aw_addr, host_aw_len, host_aw_size, host_aw_burst,
      input  host_aw_ready,
      output host_w_valid, host_w_data, host_w_strb, host_w_last,
      input  host_w_ready,
      input  host_b_valid, host_b_id, host_b_resp,
      output host_b_ready,
      output host_ar_valid, host_ar_id, host_ar_addr, host_ar_len, host_ar_size, host_ar_burst,
      input  host_ar_ready,
      input  host_r_valid, host_r_id, host_r_data, host_r_resp, host_r_last,
      output host_r_ready
   );

   modport slave (
      input  host_aw_valid, host_aw_id, host_aw_addr, host_aw_len, host_aw_size, host_aw_burst,
      output host_aw_ready,
      input  host_w_valid, host_w_data, host_w_strb, host_w_last,
      output host_w_ready,
      output host_b_valid, host_b_id, host_b_resp,
      input  host_b_ready,
      input  host_ar_valid, host_ar_id, host_ar_addr, host_ar_len, host_ar_size, host_ar_burst,
      output host_ar_ready,
      output host_r_valid, host_r_id, host_r_data, host_r_resp, host_r_last,
      input  host_r_ready
   );
endinterface

// File: rtl/axi_sram_device.sv
// rtl/axi_sram_device.sv - AXI slave backed by a byte-writable SRAM array
//
// Ports:
//   clk_i  clock
//   rst_i  asynchronous active-high reset (memory contents are not reset)
//   host   axi_sram_device_if.slave: AW/W/B write channels, AR/R read channels
// Parameters: DataWidth (32/64/128), AddrWidth, IdWidth, Depth (power of two).
// Bursts are always treated as INCR. Out-of-range or oversize bursts are
// answered with SLVERR and never touch the array.

module axi_sram_device #(
   parameter int DataWidth = 64,
   parameter int AddrWidth = 56,
   parameter int IdWidth   = 1,
   parameter int Depth     = 1024
) (
   input  logic               clk_i,
   input  logic               rst_i,
   axi_sram_device_if.slave   host
);
   localparam int         StrbW   = DataWidth / 8;
   localparam int         OffW    = $clog2(StrbW);
   localparam int         IdxW    = $clog2(Depth);
   localparam logic [2:0] MaxSize = 3'(OffW);

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
   typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

   logic [DataWidth-1:0] mem_q [Depth];

   // A burst is bad if a beat is wider than the bus or if either end of the
   // INCR run falls outside the array. Intermediate beats lie between the two
   // ends, so checking both ends covers the whole burst.
   function automatic logic burst_err(input logic [AddrWidth-1:0] addr,
                                      input logic [7:0]           len,
                                      input logic [2:0]           size);
      logic [AddrWidth-1:0] last_addr;
      last_addr = addr + (AddrWidth'(len) << size);
      return (size > MaxSize) ||
             ((addr      >> (OffW + IdxW)) != '0) ||
             ((last_addr >> (OffW + IdxW)) != '0);
   endfunction

   logic [3:0] unused_burst;
   assign unused_burst = {host.host_aw_burst, host.host_ar_burst};

   // ---------------------------------------------------------------- write path
   w_state_e             w_state_q;
   logic [IdWidth-1:0]   w_id_q;
   logic [AddrWidth-1:0] w_addr_q, w_addr_d;
   logic [7:0]           w_len_q;
   logic [2:0]           w_size_q;
   logic [7:0]           w_cnt_q;
   logic                 w_err_q;
   logic                 w_end;
   logic                 w_fire;
   logic [IdxW-1:0]      w_idx;

   assign w_addr_d = w_addr_q + (AddrWidth'(1) << w_size_q);
   assign w_end    = (w_cnt_q == w_len_q);
   assign w_fire   = host.host_w_valid && (w_state_q == W_DATA);
   assign w_idx    = w_addr_q[OffW +: IdxW];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         w_state_q <= W_IDLE;
         w_id_q    <= '0;
         w_addr_q  <= '0;
         w_len_q   <= '0;
         w_size_q  <= '0;
         w_cnt_q   <= '0;
         w_err_q   <= 1'b0;
      end else begin
         case (w_state_q)
            W_IDLE: begin
               if (host.host_aw_valid) begin
                  w_id_q    <= host.host_aw_id;
                  w_addr_q  <= host.host_aw_addr;
                  w_len_q   <= host.host_aw_len;
                  w_size_q  <= host.host_aw_size;
                  w_cnt_q   <= '0;
                  w_err_q   <= burst_err(host.host_aw_addr, host.host_aw_len, host.host_aw_size);
                  w_state_q <= W_DATA;
               end
            end
            W_DATA: begin
               if (host.host_w_valid) begin
                  w_addr_q <= w_addr_d;
                  // The counter, not w_last, decides where the burst ends;
                  // a disagreeing w_last only poisons the response.
                  if (host.host_w_last != w_end) begin
                     w_err_q <= 1'b1;
                  end
                  if (w_end) begin
                     w_state_q <= W_RESP;
                  end else begin
                     w_cnt_q <= w_cnt_q + 8'd1;
                  end
               end
            end
            W_RESP: begin
               if (host.host_b_ready) begin
                  w_state_q <= W_IDLE;
               end
            end
            default: w_state_q <= W_IDLE;
         endcase
      end
   end

   // Array write port: no reset so contents survive an abandoned burst.
   always_ff @(posedge clk_i) begin
      if (w_fire && !w_err_q) begin
         for (int b = 0; b < StrbW; b++) begin
            if (host.host_w_strb[b]) begin
               mem_q[w_idx][8*b +: 8] <= host.host_w_data[8*b +: 8];
            end
         end
      end
   end

   assign host.host_aw_ready = (w_state_q == W_IDLE);
   assign host.host_w_ready  = (w_state_q == W_DATA);
   assign host.host_b_valid  = (w_state_q == W_RESP);
   assign host.host_b_id     = w_id_q;
   assign host.host_b_resp   = w_err_q ? 2'b10 : 2'b00;

   // ----------------------------------------------------------------- read path
   r_state_e             r_state_q;
   logic [IdWidth-1:0]   r_id_q;
   logic [AddrWidth-1:0] r_addr_q, r_addr_d;
   logic [7:0]           r_len_q;
   logic [2:0]           r_size_q;
   logic [7:0]           r_cnt_q;
   logic                 r_err_q;
   logic [DataWidth-1:0] r_data_q;
   logic                 ar_err;
   logic                 r_last;

   assign r_addr_d = r_addr_q + (AddrWidth'(1) << r_size_q);
   assign ar_err   = burst_err(host.host_ar_addr, host.host_ar_len, host.host_ar_size);
   assign r_last   = (r_cnt_q == r_len_q);

   // The data register is loaded on the handshake edge of the previous beat
   // (or of AR), so r_valid can stay high across beats with no bubble and all
   // r_* outputs hold naturally while the host stalls.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state_q <= R_IDLE;
         r_id_q    <= '0;
         r_addr_q  <= '0;
         r_len_q   <= '0;
         r_size_q  <= '0;
         r_cnt_q   <= '0;
         r_err_q   <= 1'b0;
         r_data_q  <= '0;
      end else begin
         case (r_state_q)
            R_IDLE: begin
               if (host.host_ar_valid) begin
                  r_id_q    <= host.host_ar_id;
                  r_addr_q  <= host.host_ar_addr;
                  r_len_q   <= host.host_ar_len;
                  r_size_q  <= host.host_ar_size;
                  r_cnt_q   <= '0;
                  r_err_q   <= ar_err;
                  r_data_q  <= ar_err ? '0 : mem_q[host.host_ar_addr[OffW +: IdxW]];
                  r_state_q <= R_DATA;
               end
            end
            R_DATA: begin
               if (host.host_r_ready) begin
                  if (r_last) begin
                     r_state_q <= R_IDLE;
                  end else begin
                     r_cnt_q  <= r_cnt_q + 8'd1;
                     r_addr_q <= r_addr_d;
                     r_data_q <= r_err_q ? '0 : mem_q[r_addr_d[OffW +: IdxW]];
                  end
               end
            end
            default: r_state_q <= R_IDLE;
         endcase
      end
   end

   assign host.host_ar_ready = (r_state_q == R_IDLE);
   assign host.host_r_valid  = (r_state_q == R_DATA);
   assign host.host_r_id     = r_id_q;
   assign host.host_r_data   = r_data_q;
   assign host.host_r_resp   = r_err_q ? 2'b10 : 2'b00;
   assign host.host_r_last   = r_last;

endmodule

// File: tb/tb_axi_sram_device.sv
// tb/tb_axi_sram_device.sv - directed self-checking bench for axi_sram_device

module tb_axi_sram_device;
   localparam int DW    = 64;
   localparam int AW    = 56;
   localparam int IW    = 1;
   localparam int DEPTH = 1024;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   axi_sram_device_if #(.IdWidth(IW), .AddrWidth(AW), .DataWidth(DW)) bus ();

   axi_sram_device #(.DataWidth(DW), .AddrWidth(AW), .IdWidth(IW), .Depth(DEPTH)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .host  (bus)
   );

   int n_checks = 0;
   int n_err    = 0;
   logic [63:0] exp_r [256];

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic aw_send(input logic [IW-1:0] id, input logic [AW-1:0] addr,
                          input logic [7:0] len, input logic [2:0] size);
      int t = 0;
      while (!bus.host_aw_ready && t < 50) begin @(negedge clk); t++; end
      check("aw_ready", bus.host_aw_ready, 1'b1);
      bus.host_aw_valid = 1'b1;
      bus.host_aw_id    = id;
      bus.host_aw_addr  = addr;
      bus.host_aw_len   = len;
      bus.host_aw_size  = size;
      @(negedge clk);
      bus.host_aw_valid = 1'b0;
   endtask

   task automatic w_beat(input logic [63:0] data, input logic [7:0] strb, input logic last);
      int t = 0;
      while (!bus.host_w_ready && t < 50) begin @(negedge clk); t++; end
      check("w_ready", bus.host_w_ready, 1'b1);
      bus.host_w_valid = 1'b1;
      bus.host_w_data  = data;
      bus.host_w_strb  = strb;
      bus.host_w_last  = last;
      @(negedge clk);
      bus.host_w_valid = 1'b0;
   endtask

   task automatic b_expect(input string tag, input logic [IW-1:0] id, input logic [1:0] resp);
      int t = 0;
      while (!bus.host_b_valid && t < 50) begin @(negedge clk); t++; end
      check({tag, "_bvalid"}, bus.host_b_valid, 1'b1);
      check({tag, "_bid"},    bus.host_b_id,    id);
      check({tag, "_bresp"},  bus.host_b_resp,  resp);
      bus.host_b_ready = 1'b1;
      @(negedge clk);
      bus.host_b_ready = 1'b0;
   endtask

   task automatic single_write(input string tag, input logic [AW-1:0] addr,
                               input logic [63:0] data, input logic [1:0] resp);
      aw_send(1'b0, addr, 8'd0, 3'd3);
      w_beat(data, 8'hFF, 1'b1);
      b_expect(tag, 1'b0, resp);
   endtask

   // Reads len+1 beats, comparing against exp_r; optionally stalls one beat.
   task automatic read_burst(input string tag, input logic [IW-1:0] id, input logic [AW-1:0] addr,
                             input logic [7:0] len, input logic [2:0] size, input logic [1:0] resp,
                             input int stall_beat, input int stall_n);
      int t = 0;
      logic [63:0] snap_d;
      logic        snap_l;
      logic [IW-1:0] snap_i;
      while (!bus.host_ar_ready && t < 50) begin @(negedge clk); t++; end
      check({tag, "_ar_ready"}, bus.host_ar_ready, 1'b1);
      bus.host_ar_valid = 1'b1;
      bus.host_ar_id    = id;
      bus.host_ar_addr  = addr;
      bus.host_ar_len   = len;
      bus.host_ar_size  = size;
      @(negedge clk);
      bus.host_ar_valid = 1'b0;
      check({tag, "_r_latency"}, bus.host_r_valid, 1'b1);
      for (int b = 0; b <= int'(len); b++) begin
         if (b == stall_beat) begin
            bus.host_r_ready = 1'b0;
            snap_d = bus.host_r_data;
            snap_l = bus.host_r_last;
            snap_i = bus.host_r_id;
            repeat (stall_n) begin
               @(negedge clk);
               check({tag, "_hold_valid"}, bus.host_r_valid, 1'b1);
               check({tag, "_hold_data"},  bus.host_r_data,  snap_d);
               check({tag, "_hold_last"},  bus.host_r_last,  snap_l);
               check({tag, "_hold_id"},    bus.host_r_id,    snap_i);
            end
         end
         check({tag, "_rvalid"}, bus.host_r_valid, 1'b1);
         check({tag, "_rdata"},  bus.host_r_data,  exp_r[b]);
         check({tag, "_rresp"},  bus.host_r_resp,  resp);
         check({tag, "_rlast"},  bus.host_r_last,  b == int'(len));
         check({tag, "_rid"},    bus.host_r_id,    id);
         bus.host_r_ready = 1'b1;
         @(negedge clk);
      end
      bus.host_r_ready = 1'b0;
      check({tag, "_rvalid_end"}, bus.host_r_valid, 1'b0);
      check({tag, "_ar_ready_end"}, bus.host_ar_ready, 1'b1);
   endtask

   initial begin
      bus.host_aw_valid = 0; bus.host_aw_id = '0; bus.host_aw_addr = '0; bus.host_aw_len = '0;
      bus.host_aw_size = '0; bus.host_aw_burst = 2'b01;
      bus.host_w_valid = 0; bus.host_w_data = '0; bus.host_w_strb = '0; bus.host_w_last = 0;
      bus.host_b_ready = 0;
      bus.host_ar_valid = 0; bus.host_ar_id = '0; bus.host_ar_addr = '0; bus.host_ar_len = '0;
      bus.host_ar_size = '0; bus.host_ar_burst = 2'b01;
      bus.host_r_ready = 0;
      rst = 1'b1;
      repeat (3) @(negedge clk);

      check("rst_aw_ready", bus.host_aw_ready, 1'b1);
      check("rst_ar_ready", bus.host_ar_ready, 1'b1);
      check("rst_w_ready",  bus.host_w_ready,  1'b0);
      check("rst_b_valid",  bus.host_b_valid,  1'b0);
      check("rst_r_valid",  bus.host_r_valid,  1'b0);
      rst = 1'b0;
      @(negedge clk);

      // Single write, response one cycle after the W beat, then read back.
      aw_send(1'b1, 56'h10, 8'd0, 3'd3);
      w_beat(64'h1122334455667788, 8'hFF, 1'b1);
      check("single_b_latency", bus.host_b_valid, 1'b1);
      b_expect("single", 1'b1, 2'b00);
      exp_r[0] = 64'h1122334455667788;
      read_burst("single_rd", 1'b1, 56'h10, 8'd0, 3'd3, 2'b00, -1, 0);

      // Partial strobe on beat 1 of a 4-beat burst; readback with a 5-cycle stall on beat 1.
      single_write("pre_w1", 56'h8, 64'hFFEEDDCCBBAA9988, 2'b00);
      aw_send(1'b0, 56'h0, 8'd3, 3'd3);
      w_beat(64'h0101010101010101, 8'hFF, 1'b0);
      w_beat(64'h0202020202020202, 8'h0F, 1'b0);
      w_beat(64'h0303030303030303, 8'hFF, 1'b0);
      w_beat(64'h0404040404040404, 8'hFF, 1'b1);
      b_expect("burst", 1'b0, 2'b00);
      exp_r[0] = 64'h0101010101010101;
      exp_r[1] = 64'hFFEEDDCC02020202;
      exp_r[2] = 64'h0303030303030303;
      exp_r[3] = 64'h0404040404040404;
      read_burst("burst_rd", 1'b0, 56'h0, 8'd3, 3'd3, 2'b00, 1, 5);

      // Out-of-range start (would alias word 0) and oversize beat: no write, SLVERR.
      single_write("err_range", 56'h2000, 64'hDEADBEEFDEADBEEF, 2'b10);
      aw_send(1'b0, 56'h0, 8'd0, 3'd4);
      w_beat(64'hCAFECAFECAFECAFE, 8'hFF, 1'b1);
      b_expect("err_size", 1'b0, 2'b10);
      exp_r[0] = 64'h0101010101010101;
      read_burst("err_unchanged", 1'b0, 56'h0, 8'd0, 3'd3, 2'b00, -1, 0);

      // Last word is legal; a 2-beat burst starting there overruns on its final beat.
      single_write("top_ok", 56'h1FF8, 64'h7777666655554444, 2'b00);
      aw_send(1'b0, 56'h1FF8, 8'd1, 3'd3);
      w_beat(64'h1111111111111111, 8'hFF, 1'b0);
      w_beat(64'h2222222222222222, 8'hFF, 1'b1);
      b_expect("err_final", 1'b0, 2'b10);
      exp_r[0] = 64'h7777666655554444;
      read_burst("top_rd", 1'b0, 56'h1FF8, 8'd0, 3'd3, 2'b00, -1, 0);

      // Errored reads: zero data and SLVERR on every beat.
      exp_r[0] = '0;
      exp_r[1] = '0;
      read_burst("rerr_range", 1'b1, 56'h2000, 8'd1, 3'd3, 2'b10, -1, 0);
      read_burst("rerr_final", 1'b0, 56'h1FF8, 8'd1, 3'd3, 2'b10, -1, 0);
      read_burst("rerr_size",  1'b1, 56'h0,    8'd0, 3'd4, 2'b10, -1, 0);

      // w_last asserted early: the burst still needs two beats and ends in SLVERR.
      aw_send(1'b1, 56'h20, 8'd1, 3'd3);
      w_beat(64'hABABABABABABABAB, 8'hFF, 1'b1);
      check("wlast_no_b_early", bus.host_b_valid, 1'b0);
      check("wlast_w_ready",    bus.host_w_ready, 1'b1);
      w_beat(64'hCDCDCDCDCDCDCDCD, 8'hFF, 1'b1);
      b_expect("wlast", 1'b1, 2'b10);

      // Reset pulse during beat 2 of a 4-beat burst.
      single_write("pre_50", 56'h50, 64'h5555555555555555, 2'b00);
      aw_send(1'b0, 56'h40, 8'd3, 3'd3);
      w_beat(64'hE0E0E0E0E0E0E0E0, 8'hFF, 1'b0);
      w_beat(64'hE1E1E1E1E1E1E1E1, 8'hFF, 1'b0);
      bus.host_w_valid = 1'b1;
      bus.host_w_data  = 64'hE2E2E2E2E2E2E2E2;
      bus.host_w_strb  = 8'hFF;
      bus.host_w_last  = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      bus.host_w_valid = 1'b0;
      check("rst_mid_aw_ready", bus.host_aw_ready, 1'b1);
      check("rst_mid_w_ready",  bus.host_w_ready,  1'b0);
      for (int i = 0; i < 6; i++) begin
         check("rst_mid_no_b", bus.host_b_valid, 1'b0);
         @(negedge clk);
      end
      exp_r[0] = 64'hE0E0E0E0E0E0E0E0;
      exp_r[1] = 64'hE1E1E1E1E1E1E1E1;
      exp_r[2] = 64'h5555555555555555;
      read_burst("rst_mid_rd", 1'b0, 56'h40, 8'd2, 3'd3, 2'b00, -1, 0);

      // Maximum burst length: 256 beats written and read back.
      aw_send(1'b1, 56'h800, 8'd255, 3'd3);
      for (int i = 0; i < 256; i++) begin
         exp_r[i] = {32'(i) ^ 32'hA5A50000, ~32'(i)};
         w_beat(exp_r[i], 8'hFF, i == 255);
      end
      b_expect("len255", 1'b1, 2'b00);
      read_burst("len255_rd", 1'b1, 56'h800, 8'd255, 3'd3, 2'b00, -1, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
